instruction_fetcher: RTL and testbench
======================================

INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter IQ_DEPTH, default 16: instruction-queue entries, power of two.
REQ-003 Parameter BHT_SIZE, default 256: 2-bit branch-history counters, indexed by pc[9:2].
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 rdy  in  1  global enable; when low, all state holds.
REQ-007 icache_req_valid  out  1  fetch request.
REQ-008 icache_addr  out  32  fetch address, word aligned.
REQ-009 icache_resp_valid  in  1  response strobe, at least 1 cycle after the request.
REQ-010 icache_instr  in  32  fetched word.
REQ-011 stall  in  1  downstream cannot accept an instruction this cycle.
REQ-012 flush  in  1  misprediction redirect.
REQ-013 flush_pc  in  32  redirect target.
REQ-014 bp_update_valid  in  1  committed branch outcome.
REQ-015 bp_update_pc  in  32  pc of the committed branch.
REQ-016 bp_update_taken  in  1  actual outcome.
REQ-017 instr_out_valid  out  1  issue strobe (feeds instr_in_valid).
REQ-018 instr_out  out  32  instruction word.
REQ-019 pc_out  out  32  instruction pc.
REQ-020 jumped_out  out  1  fetch followed the predicted-taken path.

Function
REQ-021 FSM states: IDLE (no request outstanding) and WAIT (one request outstanding); at most one request is in flight.
REQ-022 IDLE->WAIT: the block SHALL assert icache_req_valid with icache_addr=fetch_pc when queue count plus in-flight is below IQ_DEPTH.
REQ-023 WAIT->IDLE on icache_resp_valid; the word is predecoded, pushed {instr, pc, jumped}, and fetch_pc is updated in the same edge.
REQ-024 Next fetch_pc: JAL = pc+immJ with jumped=1; B-type = pc+immB with jumped=1 if BHT[pc[9:2]][1], otherwise pc+4 with jumped=0; all others, including JALR, = pc+4 with jumped=0.
REQ-025 Immediates SHALL be sign-extended to 32 bits; address sums wrap modulo 2^32.
REQ-026 Output stage is registered: when not stall and queue not empty, pop the head into the outputs with instr_out_valid=1; otherwise instr_out_valid=0 the next cycle.
REQ-027 Issue rate is at most one instruction per cycle; a response-to-instr_out_valid latency of 2 edges (push, then pop) is the minimum.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and SHALL be legal when full.
REQ-029 Read and write pointers SHALL wrap from IQ_DEPTH-1 to 0.
REQ-030 Flush SHALL take priority over everything except rst; at the next edge the queue empties, instr_out_valid=0, and fetch_pc=flush_pc.
REQ-031 After a flush, the FSM SHALL stay in WAIT if a request was outstanding and SHALL set a drop flag so that response is discarded; a new request is issued only after that.
REQ-032 BHT update: the saturating counter increments on taken and decrements on not-taken, and occurs regardless of flush.
REQ-033 BHT read and update to the same index in one cycle: the read SHALL return the old value.
REQ-034 When rdy is low, no push, pop, request, or BHT update occurs; an icache response arriving then is the caller's responsibility.

Reset
REQ-035 On rst: fetch_pc=0, FSM=IDLE, drop flag=0, pointers and count=0, icache_req_valid=0, instr_out_valid=0, and instr_out/pc_out/jumped_out=0.
REQ-036 On rst, all BHT counters SHALL reset to 2'b01 (weakly not-taken), including when rst is asserted mid-request (the pending response is ignored).

Structure
REQ-037 Opcode constants (JAL, JALR, BRANCH) and IQ_DEPTH/BHT_SIZE defaults SHALL reside in the shared config header.
REQ-038 The BHT SHALL be a sub-module named branch_predictor with a read index, an update port, and a taken output.

Verification
REQ-039 Straight-line fetch, 3 ADDI words at 0x0, 0x4, 0x8: outputs pc_out 0x0, 0x4, 0x8 on consecutive cycles, with jumped_out=0.
REQ-040 JAL x0,+16 at 0x0: next icache_addr=0x10, and jumped_out=1 for pc 0x0.
REQ-041 BEQ at 0x20 with offset -8, after 2 bp_update_taken=1 updates: next icache_addr=0x18 and jumped_out=1; from reset state, next icache_addr=0x24.
REQ-042 Hold stall=1 until the queue holds 16 entries: no further icache_req_valid; on release, 16 pops occur in order, with no loss across pointer wrap.
REQ-043 Flush with flush_pc=0x100 while in WAIT: the old response is discarded, the queue is empty, and the first new request is to 0x100.
REQ-044 rst asserted mid-WAIT with a pending response: all outputs are 0 immediately (async), and the first request after release is to 0x0.

Source files
------------

// File: rtl/instruction_fetcher_pkg.sv
// Shared configuration for the instruction fetcher: queue and predictor
// sizing defaults, RV32 control-flow opcodes, FSM state type, queue entry
// layout and the immediate decoders used by the next-pc predecode.
package instruction_fetcher_pkg;

    localparam int IQ_DEPTH_DEFAULT = 16;
    localparam int BHT_SIZE_DEFAULT = 256;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jumped;
    } iq_entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (counters -> 2'b01)
//   rdy              global enable; updates only happen while high
//   rd_idx           read index; taken = MSB of the addressed counter
//   upd_valid/idx/taken  committed branch outcome to train the table
// The read is a plain combinational lookup of the current array, so a read
// and an update of the same index in one cycle sees the pre-update value.
module branch_predictor
    import instruction_fetcher_pkg::*;
#(
    parameter int BHT_SIZE = BHT_SIZE_DEFAULT,
    parameter int IDX_W    = $clog2(BHT_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             taken
);

    logic [BHT_SIZE-1:0][1:0] bht;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht <= {BHT_SIZE{2'b01}};
        end else if (rdy && upd_valid) begin
            if (upd_taken) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    assign taken = bht[rd_idx][1];

endmodule

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: one-outstanding-request icache fetch FSM, predecode of
// JAL / conditional branches for next-pc selection, instruction queue and a
// registered issue stage.
// Ports:
//   clk, rst, rdy                      clock, async active-high reset, global enable
//   icache_req_valid, icache_addr      fetch request (one-cycle pulse) and address
//   icache_resp_valid, icache_instr    fetch response
//   stall                              downstream back-pressure
//   flush, flush_pc                    misprediction redirect
//   bp_update_valid/pc/taken           committed branch outcome for the BHT
//   instr_out_valid, instr_out, pc_out, jumped_out   issued instruction
//
// state   | meaning
// ST_IDLE | no request outstanding; issue one when the queue has room
// ST_WAIT | one request outstanding; drop set means its response is stale
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter int BHT_SIZE = BHT_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        icache_req_valid,
    output logic [31:0] icache_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        bp_update_valid,
    input  logic [31:0] bp_update_pc,
    input  logic        bp_update_taken,
    output logic        instr_out_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        jumped_out
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(BHT_SIZE);

    fetch_state_e     state, state_nxt;
    logic             drop, drop_nxt;
    logic             req_nxt;
    logic [31:0]      fetch_pc, fetch_pc_nxt;
    logic [31:0]      resp_next_pc;
    iq_entry_t        push_entry;
    iq_entry_t        iq_mem [IQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    logic             bp_taken;
    logic             unused_bp_pc_bits;

    assign unused_bp_pc_bits = ^{bp_update_pc[31:IDX_W+2], bp_update_pc[1:0]};

    branch_predictor #(.BHT_SIZE(BHT_SIZE)) u_branch_predictor (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (fetch_pc[IDX_W+1:2]),
        .upd_valid (bp_update_valid),
        .upd_idx   (bp_update_pc[IDX_W+1:2]),
        .upd_taken (bp_update_taken),
        .taken     (bp_taken)
    );

    assign icache_addr = {fetch_pc[31:2], 2'b00};

    // Predecode of the returning word: the entry is tagged with the pc it was
    // fetched from, and the next fetch pc follows the predicted path.
    always_comb begin
        push_entry.instr  = icache_instr;
        push_entry.pc     = fetch_pc;
        push_entry.jumped = 1'b0;
        resp_next_pc      = fetch_pc + 32'd4;
        case (icache_instr[6:0])
            OPC_JAL: begin
                resp_next_pc      = fetch_pc + imm_j(icache_instr);
                push_entry.jumped = 1'b1;
            end
            OPC_BRANCH: begin
                if (bp_taken) begin
                    resp_next_pc      = fetch_pc + imm_b(icache_instr);
                    push_entry.jumped = 1'b1;
                end
            end
            OPC_JALR: resp_next_pc = fetch_pc + 32'd4;
            default:  resp_next_pc = fetch_pc + 32'd4;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        drop_nxt     = drop;
        req_nxt      = 1'b0;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        if (!rdy) begin
            req_nxt = icache_req_valid;
        end else if (flush) begin
            fetch_pc_nxt = flush_pc;
            // A request still in flight must be waited out and its data thrown
            // away; a response landing on the flush cycle is simply consumed.
            if (state == ST_WAIT && !icache_resp_valid) begin
                state_nxt = ST_WAIT;
                drop_nxt  = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
                drop_nxt  = 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count < CNT_W'(IQ_DEPTH)) begin
                        state_nxt = ST_WAIT;
                        req_nxt   = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (icache_resp_valid) begin
                        state_nxt = ST_IDLE;
                        drop_nxt  = 1'b0;
                        if (!drop) begin
                            push         = 1'b1;
                            fetch_pc_nxt = resp_next_pc;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign pop = rdy && !flush && !stall && (count != '0);

    always_ff @(posedge clk) begin
        if (push) iq_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            drop             <= 1'b0;
            icache_req_valid <= 1'b0;
            fetch_pc         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            instr_out_valid  <= 1'b0;
            instr_out        <= '0;
            pc_out           <= '0;
            jumped_out       <= 1'b0;
        end else begin
            state            <= state_nxt;
            drop             <= drop_nxt;
            icache_req_valid <= req_nxt;
            fetch_pc         <= fetch_pc_nxt;
            if (rdy) begin
                if (flush) begin
                    wr_ptr          <= '0;
                    rd_ptr          <= '0;
                    count           <= '0;
                    instr_out_valid <= 1'b0;
                end else begin
                    instr_out_valid <= pop;
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        instr_out  <= iq_mem[rd_ptr].instr;
                        pc_out     <= iq_mem[rd_ptr].pc;
                        jumped_out <= iq_mem[rd_ptr].jumped;
                    end
                    if (push && !pop) count <= count + 1'b1;
                    else if (pop && !push) count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
module tb_instruction_fetcher;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jumped;
    } exp_t;

    localparam logic [31:0] ADDI_WORD = 32'h00108093;  // addi x1,x1,1
    localparam logic [31:0] JAL_P16   = 32'h0100006F;  // jal x0,+16
    localparam logic [31:0] BEQ_M8    = 32'hFE000CE3;  // beq x0,x0,-8

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        icache_req_valid;
    logic [31:0] icache_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_instr;
    logic        stall = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        bp_update_valid = 1'b0;
    logic [31:0] bp_update_pc = '0;
    logic        bp_update_taken = 1'b0;
    logic        instr_out_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        jumped_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_cnt = 0;
    int resp_count = 0;
    int resp_lat = 1;
    bit resp_en = 1'b1;
    bit sb_discard_next = 1'b0;

    logic [31:0] mem [logic [31:0]];
    bit          jmp [logic [31:0]];
    exp_t        exp_q [$];
    logic [31:0] req_addr_q [$];
    logic [31:0] out_pc_q [$];
    int          out_cyc_q [$];

    instruction_fetcher dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .icache_req_valid  (icache_req_valid),
        .icache_addr       (icache_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_instr      (icache_instr),
        .stall             (stall),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .bp_update_valid   (bp_update_valid),
        .bp_update_pc      (bp_update_pc),
        .bp_update_taken   (bp_update_taken),
        .instr_out_valid   (instr_out_valid),
        .instr_out         (instr_out),
        .pc_out            (pc_out),
        .jumped_out        (jumped_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ADDI_WORD;
    endfunction

    function automatic bit jmp_at(input logic [31:0] a);
        if (jmp.exists(a)) return jmp[a];
        return 1'b0;
    endfunction

    // icache model: answers each request resp_lat cycles later and records
    // the expected issued entry for the scoreboard.
    initial begin
        logic [31:0] a;
        icache_resp_valid = 1'b0;
        icache_instr      = '0;
        forever begin
            @(negedge clk);
            if (!rst && resp_en && icache_req_valid) begin
                a = icache_addr;
                req_addr_q.push_back(a);
                req_cnt++;
                repeat (resp_lat) @(negedge clk);
                icache_instr      = word_at(a);
                icache_resp_valid = 1'b1;
                if (sb_discard_next) sb_discard_next = 1'b0;
                else exp_q.push_back('{instr: word_at(a), pc: a, jumped: jmp_at(a)});
                resp_count++;
                @(negedge clk);
                icache_resp_valid = 1'b0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every issued instruction.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && instr_out_valid) begin
            out_pc_q.push_back(pc_out);
            out_cyc_q.push_back(cyc);
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", instr_out, e.instr);
                chk("sb_pc", pc_out, e.pc);
                chk("sb_jumped", 32'(jumped_out), 32'(e.jumped));
            end
        end
    end

    task automatic wait_req(input int n, input string tag);
        int budget;
        budget = 300;
        while (req_cnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, 32'(req_cnt >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        bp_update_valid = 1'b0;
        repeat (8) @(negedge clk);
        exp_q.delete();
        req_addr_q.delete();
        out_pc_q.delete();
        out_cyc_q.delete();
        mem.delete();
        jmp.delete();
        req_cnt = 0;
        resp_count = 0;
        sb_discard_next = 1'b0;
    endtask

    initial begin
        int budget;
        do_reset();
        chk("rst_req_valid", 32'(icache_req_valid), 32'd0);
        chk("rst_icache_addr", icache_addr, 32'h0);
        chk("rst_out_valid", 32'(instr_out_valid), 32'd0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_jumped_out", 32'(jumped_out), 32'd0);

        // Straight-line fill to full under stall, then drain across the wrap.
        stall = 1'b1; resp_en = 1'b1; resp_lat = 1;
        rst = 1'b0;
        budget = 400;
        while (resp_count < 16 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("fill_responses", 32'(resp_count), 32'd16);
        repeat (20) @(negedge clk);
        chk("full_no_more_req", 32'(req_cnt), 32'd16);
        resp_en = 1'b0;
        stall = 1'b0;
        repeat (25) @(negedge clk);
        chk("drain_count", 32'(out_pc_q.size()), 32'd16);
        for (int i = 0; i < out_pc_q.size() && i < 16; i++)
            chk("drain_pc", out_pc_q[i], 32'(4 * i));
        for (int i = 1; i < out_cyc_q.size() && i < 16; i++)
            chk("drain_gap", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd1);

        // JAL x0,+16 at 0x0.
        do_reset();
        mem[32'h0] = JAL_P16; jmp[32'h0] = 1'b1;
        stall = 1'b1; resp_en = 1'b1;
        rst = 1'b0;
        wait_req(2, "jal_wait");
        resp_en = 1'b0;
        if (req_addr_q.size() >= 2) chk("jal_target", req_addr_q[1], 32'h10);
        stall = 1'b0;
        repeat (12) @(negedge clk);
        chk("jal_out_count", 32'(out_pc_q.size()), 32'd2);

        // BEQ -8 at 0x20 with the predictor in its reset state.
        do_reset();
        mem[32'h20] = BEQ_M8; jmp[32'h20] = 1'b0;
        stall = 1'b1; resp_en = 1'b1;
        flush = 1'b1; flush_pc = 32'h20;
        rst = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        wait_req(2, "beq_nt_wait");
        resp_en = 1'b0;
        if (req_addr_q.size() >= 2) begin
            chk("beq_nt_first", req_addr_q[0], 32'h20);
            chk("beq_nt_next", req_addr_q[1], 32'h24);
        end
        stall = 1'b0;
        repeat (12) @(negedge clk);
        chk("beq_nt_out_count", 32'(out_pc_q.size()), 32'd2);

        // Same branch after two taken updates (applied while fetch is held by flush).
        do_reset();
        mem[32'h20] = BEQ_M8; jmp[32'h20] = 1'b1;
        stall = 1'b1; resp_en = 1'b1;
        flush = 1'b1; flush_pc = 32'h20;
        bp_update_valid = 1'b1; bp_update_pc = 32'h20; bp_update_taken = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bp_update_valid = 1'b0;
        flush = 1'b0;
        wait_req(2, "beq_t_wait");
        resp_en = 1'b0;
        if (req_addr_q.size() >= 2) chk("beq_t_next", req_addr_q[1], 32'h18);
        stall = 1'b0;
        repeat (12) @(negedge clk);
        chk("beq_t_out_count", 32'(out_pc_q.size()), 32'd2);

        // Flush while a request is outstanding: its response must be dropped.
        do_reset();
        stall = 1'b1; resp_en = 1'b1; resp_lat = 4;
        rst = 1'b0;
        wait_req(1, "flush_wait1");
        sb_discard_next = 1'b1;
        flush = 1'b1; flush_pc = 32'h100;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", 32'(instr_out_valid), 32'd0);
        wait_req(2, "flush_wait2");
        resp_en = 1'b0;
        if (req_addr_q.size() >= 2) chk("flush_new_req", req_addr_q[1], 32'h100);
        stall = 1'b0;
        repeat (15) @(negedge clk);
        chk("flush_out_count", 32'(out_pc_q.size()), 32'd1);
        if (out_pc_q.size() >= 1) chk("flush_out_pc", out_pc_q[0], 32'h100);

        // Asynchronous reset while a request is outstanding.
        do_reset();
        stall = 1'b0; resp_en = 1'b1; resp_lat = 1;
        rst = 1'b0;
        wait_req(3, "arst_wait");
        #2 rst = 1'b1;
        #1;
        chk("arst_req_valid", 32'(icache_req_valid), 32'd0);
        chk("arst_icache_addr", icache_addr, 32'h0);
        chk("arst_out_valid", 32'(instr_out_valid), 32'd0);
        chk("arst_instr_out", instr_out, 32'h0);
        chk("arst_pc_out", pc_out, 32'h0);
        chk("arst_jumped_out", 32'(jumped_out), 32'd0);
        do_reset();
        rst = 1'b0;
        wait_req(1, "arst_wait_after");
        if (req_addr_q.size() >= 1) chk("arst_first_req", req_addr_q[0], 32'h0);
        repeat (10) @(negedge clk);
        resp_en = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
